sampa_pon_txn_sequencer: RTL and testbench

//  Upstream controller for the SAMPA power-on AXI master. Runs N_STEPS power-on steps in order.
//  Per step: wait a settling delay, pulse the master's INIT_AXI_TXN, then wait for TXN_DONE and check ERROR.
//  A failed step is retried; a hung step is caught by a timeout. Reports done/fail status to the PS register bank.

---
 rtl/sampa_pon_txn_sequencer.sv | 155 +++++++++++++++
 tb/tb_sampa_pon_txn_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampa_pon_txn_sequencer.sv
// Power-on step sequencer for the SAMPA AXI master:
// settle, fire INIT, await TXN_DONE, retry or time out.
module sampa_pon_txn_sequencer #(
  parameter int N_STEPS        = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3,
  localparam int SW   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int RW   = $clog2(MAX_RETRY + 2),
  localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES)
                      ? SETTLE_CYCLES : TIMEOUT_CYCLES,
  localparam int CW   = $clog2(CMAX + 1)
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic                abort,
  output logic                M00_AXI_INIT_AXI_TXN,
  input  logic                M00_AXI_TXN_DONE,
  input  logic                M00_AXI_ERROR,
  output logic [SW-1:0]       step_idx,
  output logic [N_STEPS-1:0]  step_sel,
  output logic [RW-1:0]       retry_cnt,
  output logic                busy,
  output logic                seq_done,
  output logic                seq_fail,
  output logic [1:0]          fail_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_FIRE, S_WAIT,
    S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      code_q, code_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic            init_q, init_d;
  logic            busy_s;

  assign busy_s = (state_q == S_DELAY) ||
                  (state_q == S_FIRE)  ||
                  (state_q == S_WAIT)  ||
                  (state_q == S_CHECK);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start && abort) begin
          state_d = S_FAIL;
          code_d  = 2'b11;
        end else if (start) begin
          state_d = S_DELAY;
          step_d  = '0;
          retry_d = '0;
          code_d  = 2'b00;
          cnt_d   = '0;
        end
      end
      S_DELAY: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else if (cnt_q != CW'(CMAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // cnt_q==0 is the first WAIT cycle: a stale DONE is ignored there
        if ((cnt_q != '0) && M00_AXI_TXN_DONE) begin
          state_d = S_CHECK;
          err_d   = M00_AXI_ERROR;
          tmo_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_CHECK;
          err_d   = 1'b0;
          tmo_d   = 1'b1;
        end else if (cnt_q != CW'(CMAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (!err_q && !tmo_q) begin
          if (step_q == SW'(N_STEPS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DELAY;
            step_d  = step_q + 1'b1;
            retry_d = '0;
          end
        end else if (retry_q < RW'(MAX_RETRY)) begin
          state_d = S_DELAY;
          retry_d = retry_q + 1'b1;
        end else begin
          state_d = S_FAIL;
          code_d  = err_q ? 2'b01 : 2'b10;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && busy_s) begin
      state_d = S_FAIL;
      code_d  = 2'b11;
    end
    init_d = (state_d == S_FIRE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      code_q  <= 2'b00;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      init_q  <= init_d;
    end
  end

  assign M00_AXI_INIT_AXI_TXN = init_q;
  assign step_idx  = step_q;
  assign retry_cnt = retry_q;
  assign fail_code = code_q;
  assign busy      = busy_s;
  assign seq_done  = (state_q == S_DONE);
  assign seq_fail  = (state_q == S_FAIL);
  assign step_sel  = busy_s ? (N_STEPS'(1) << step_q) : '0;

endmodule

// File: tb/tb_sampa_pon_txn_sequencer.sv
// Scoreboard bench: directed scenarios push expected INIT/end
// events; a monitor pops them as the sequencer emits them.
module tb_sampa_pon_txn_sequencer;

  localparam int NS = 4;
  localparam int ST = 8;
  localparam int TO = 64;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       done = 1'b0;
  logic       err = 1'b0;
  logic       init;
  logic [1:0] step_idx;
  logic [3:0] step_sel;
  logic [2:0] retry_cnt;
  logic       busy, sdone, sfail;
  logic [1:0] code;

  sampa_pon_txn_sequencer #(
    .N_STEPS(NS), .SETTLE_CYCLES(ST),
    .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .start(start), .abort(abort),
    .M00_AXI_INIT_AXI_TXN(init),
    .M00_AXI_TXN_DONE(done),
    .M00_AXI_ERROR(err),
    .step_idx(step_idx), .step_sel(step_sel),
    .retry_cnt(retry_cnt), .busy(busy),
    .seq_done(sdone), .seq_fail(sfail),
    .fail_code(code)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit is_end;
    int step;
    int retry;
    int gap;
    int dn;
    int fl;
    int cd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   init_seen = 0;
  int   last_init = 0;
  int   lat[16];
  bit   erp[16];
  bit   nev[16];
  bit   hold[16];
  int   att = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic exp_init(input int s, input int r, input int g);
    exp_t e;
    e = '{is_end: 1'b0, step: s, retry: r, gap: g, dn: 0, fl: 0, cd: 0};
    q.push_back(e);
  endtask

  task automatic exp_end(input int dn, input int fl, input int cd,
                         input int s, input int r);
    exp_t e;
    e = '{is_end: 1'b1, step: s, retry: r, gap: 0, dn: dn, fl: fl, cd: cd};
    q.push_back(e);
  endtask

  task automatic set_plan();
    for (int i = 0; i < 16; i++) begin
      lat[i] = 10; erp[i] = 1'b0;
      nev[i] = 1'b0; hold[i] = 1'b0;
    end
    att = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sdone || sfail) begin ok = 1; break; end
    end
    chk({nm, "_end_seen"}, ok, 1);
    @(posedge clk); #1;
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  task automatic wait_init(input string nm, input int n, input int budget);
    int ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (init_seen >= n) begin ok = 1; break; end
    end
    chk(nm, ok, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI master model: answers each INIT per the attempt plan
  initial begin : resp
    int a;
    forever begin
      @(negedge clk);
      if (init === 1'b1) begin
        a = att;
        att++;
        if (!nev[a]) begin
          repeat (lat[a]) @(posedge clk);
          #1;
          done = 1'b1;
          err = erp[a];
          if (!hold[a]) begin
            @(posedge clk); #1;
            done = 1'b0;
            err = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mon
    exp_t e;
    bit   pe;
    bit   en;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (init === 1'b1) begin
        init_seen++;
        chk("init_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("init_kind", int'(e.is_end), 0);
          chk("init_step", int'(step_idx), e.step);
          chk("init_retry", int'(retry_cnt), e.retry);
          chk("init_sel", int'(step_sel), 1 << e.step);
          chk("init_busy", int'(busy), 1);
          if (e.gap != 0)
            chk("init_gap", cyc - last_init, e.gap);
        end
        last_init = cyc;
      end
      en = sdone | sfail;
      if (en && !pe) begin
        chk("end_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("end_kind", int'(e.is_end), 1);
          chk("end_done", int'(sdone), e.dn);
          chk("end_fail", int'(sfail), e.fl);
          chk("end_code", int'(code), e.cd);
          chk("end_step", int'(step_idx), e.step);
          chk("end_retry", int'(retry_cnt), e.retry);
          chk("end_busy", int'(busy), 0);
        end
      end
      pe = en;
    end
  end

  initial begin : main
    int s;
    set_plan();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sdone), 0);
    chk("rst_fail", int'(sfail), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_sel", int'(step_sel), 0);
    chk("rst_init", int'(init), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // start+abort together in IDLE: abort wins
    exp_end(0, 1, 3, 0, 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t0_fail", int'(sfail), 1);
    @(posedge clk); #1;
    chk("t0_drained", q.size(), 0);

    // T1: four clean steps, plus a start while busy
    set_plan();
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(2, 0, 20);
    exp_init(3, 0, 20);
    exp_end(1, 0, 0, 3, 0);
    s = init_seen;
    pulse_start();
    wait_init("t1_first_init", s + 1, 100);
    pulse_start();
    wait_end("t1", 500);

    // T2: step 1 errors twice, then succeeds
    set_plan();
    erp[1] = 1'b1; erp[2] = 1'b1;
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(1, 1, 20);
    exp_init(1, 2, 20);
    exp_init(2, 0, 20);
    exp_init(3, 0, 20);
    exp_end(1, 0, 0, 3, 0);
    pulse_start();
    wait_end("t2", 800);

    // T3: step 2 hangs every attempt
    set_plan();
    for (int i = 2; i < 6; i++) nev[i] = 1'b1;
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(2, 0, 20);
    exp_init(2, 1, 74);
    exp_init(2, 2, 74);
    exp_init(2, 3, 74);
    exp_end(0, 1, 2, 2, 3);
    pulse_start();
    wait_end("t3", 2000);

    // T4: abort during WAIT of step 0, then rerun
    set_plan();
    nev[0] = 1'b1;
    exp_init(0, 0, 0);
    exp_end(0, 1, 3, 0, 0);
    s = init_seen;
    pulse_start();
    wait_init("t4_init", s + 1, 100);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    chk("t4_fail_next", int'(sfail), 1);
    chk("t4_code", int'(code), 3);
    abort = 1'b0;
    s = init_seen;
    repeat (40) @(posedge clk);
    #1;
    chk("t4_no_init", init_seen, s);
    chk("t4_drained", q.size(), 0);
    set_plan();
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(2, 0, 20);
    exp_init(3, 0, 20);
    exp_end(1, 0, 0, 3, 0);
    pulse_start();
    wait_end("t4_rerun", 500);

    // T5: reset pulse during DELAY of step 3
    set_plan();
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(2, 0, 20);
    pulse_start();
    s = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (step_idx == 2'd3 && busy) begin s = 1; break; end
    end
    chk("t5_reach_step3", s, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(sdone), 0);
    chk("t5_fail", int'(sfail), 0);
    chk("t5_step", int'(step_idx), 0);
    chk("t5_retry", int'(retry_cnt), 0);
    chk("t5_sel", int'(step_sel), 0);
    chk("t5_init", int'(init), 0);
    s = init_seen;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_init", init_seen, s);
    chk("t5_drained", q.size(), 0);

    // T6: stale DONE level, then DONE coincident with timeout
    set_plan();
    hold[0] = 1'b1;
    lat[1] = 2;
    lat[2] = TO;
    exp_init(0, 0, 0);
    exp_init(1, 0, 20);
    exp_init(2, 0, 12);
    exp_init(3, 0, 74);
    exp_end(1, 0, 0, 3, 0);
    pulse_start();
    wait_end("t6", 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
